// File: rtl/trng_ctrl_if.sv
// Output stream from the TRNG controller FIFO to its consumer.
// The producer drives rdata/rvalid; the consumer drives rready.
interface trng_ctrl_if #(
  parameter int DW = 64
);
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          rready;

  modport master (output rdata, output rvalid, input rready);
  modport slave  (input rdata, input rvalid, output rready);
endinterface

// File: rtl/trng_ctrl.sv
// Sequencer for the ring-oscillator TRNG: warm-up, discard, online health
// tests (repetition, stall timeout) and a small output FIFO.
//
// state   | meaning
// IDLE    | core disabled, waiting for start
// WARMUP  | core enabled, counting down warm-up cycles, words ignored
// DISCARD | dropping the first DISCARD_WORDS words, timeout armed
// RUN     | health-testing words and pushing them into the FIFO
// FAULT   | core disabled, FIFO flushed, waiting for clear_fault
module trng_ctrl #(
  parameter int WARMUP_CYCLES  = 1000,
  parameter int DISCARD_WORDS  = 2,
  parameter int REP_LIMIT      = 3,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int DEPTH          = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       clear_fault,
  output logic                       trng_enable,
  input  logic [63:0]                trng_data,
  input  logic                       trng_valid,
  trng_ctrl_if.master                rd,
  output logic                       busy,
  output logic                       fault,
  output logic [1:0]                 fault_code,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [15:0]                drop_cnt
);

  localparam int WW  = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int TW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DCW = (DISCARD_WORDS > 1) ? $clog2(DISCARD_WORDS) : 1;
  localparam int RW  = $clog2(REP_LIMIT);
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int PW  = $clog2(DEPTH);

  localparam logic [WW-1:0]  WU_LOAD  = WW'(WARMUP_CYCLES - 1);
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DCW-1:0] DC_LAST  = DCW'((DISCARD_WORDS > 0) ? DISCARD_WORDS - 1 : 0);
  localparam logic [RW-1:0]  REP_TRIP = RW'(REP_LIMIT - 2);
  localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

  typedef enum logic [2:0] {
    IDLE, WARMUP, DISCARD, RUN, FAULT
  } state_t;

  state_t         state;
  logic [WW-1:0]  wu_cnt;
  logic [TW-1:0]  to_cnt;
  logic [DCW-1:0] disc_cnt;
  logic [RW-1:0]  rep_cnt;
  logic [63:0]    last_word;

  logic [63:0]    mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [LW-1:0]  level;

  logic same_word, rep_hit, to_hit, fault_ev, start_go;
  logic pop, full, push_req, push, drop;

  always_comb begin
    same_word = (trng_data == last_word);
    rep_hit   = (state == RUN) && trng_valid && same_word && (rep_cnt == REP_TRIP);
    to_hit    = ((state == DISCARD) || (state == RUN)) && !trng_valid && (to_cnt == TO_LAST);
    fault_ev  = rep_hit || to_hit;
    start_go  = (state == IDLE) && start && !stop;
    pop       = rd.rvalid && rd.rready;
    full      = (level == LVL_FULL);
    // a word coincident with stop or with a detected fault never enters the FIFO
    push_req  = (state == RUN) && trng_valid && !fault_ev && !stop;
    push      = push_req && (!full || pop);
    drop      = push_req && full && !pop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      trng_enable <= 1'b0;
      busy        <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= 2'b00;
      wu_cnt      <= '0;
      to_cnt      <= '0;
      disc_cnt    <= '0;
      rep_cnt     <= '0;
      last_word   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_go) begin
            state       <= WARMUP;
            trng_enable <= 1'b1;
            busy        <= 1'b1;
            wu_cnt      <= WU_LOAD;
            rep_cnt     <= '0;
          end
        end
        WARMUP: begin
          if (stop) begin
            state       <= IDLE;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
          end else if (wu_cnt == '0) begin
            state    <= (DISCARD_WORDS == 0) ? RUN : DISCARD;
            to_cnt   <= '0;
            disc_cnt <= '0;
          end else begin
            wu_cnt <= wu_cnt - WW'(1);
          end
        end
        DISCARD: begin
          if (to_hit) begin
            state       <= FAULT;
            fault_code  <= 2'b10;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b1;
          end else if (stop) begin
            state       <= IDLE;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
          end else if (trng_valid) begin
            last_word <= trng_data;
            to_cnt    <= '0;
            if (disc_cnt == DC_LAST) state <= RUN;
            else disc_cnt <= disc_cnt + DCW'(1);
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        RUN: begin
          if (fault_ev) begin
            state       <= FAULT;
            fault_code  <= rep_hit ? 2'b01 : 2'b10;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
            fault       <= 1'b1;
          end else if (stop) begin
            state       <= IDLE;
            trng_enable <= 1'b0;
            busy        <= 1'b0;
          end else if (trng_valid) begin
            last_word <= trng_data;
            to_cnt    <= '0;
            rep_cnt   <= same_word ? rep_cnt + RW'(1) : '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        FAULT: begin
          if (clear_fault) begin
            state      <= IDLE;
            fault      <= 1'b0;
            fault_code <= 2'b00;
          end
        end
        default: begin
          state       <= IDLE;
          trng_enable <= 1'b0;
          busy        <= 1'b0;
          fault       <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (fault_ev) begin
        rd_ptr <= wr_ptr;
        level  <= '0;
      end else begin
        if (push) begin
          mem[wr_ptr] <= trng_data;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   level <= level + LW'(1);
          2'b01:   level <= level - LW'(1);
          default: level <= level;
        endcase
      end
      if (start_go) drop_cnt <= '0;
      else if (drop && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign rd.rdata  = mem[rd_ptr];
  assign rd.rvalid = (level != '0);
  assign fifo_level = level;

endmodule

// File: tb/tb_trng_ctrl.sv
// Directed bench for trng_ctrl: stimulus pushes expected FIFO words into a
// queue, a negedge monitor checks each handshake against it.
module tb_trng_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, stop = 1'b0, clear_fault = 1'b0;
  logic        trng_enable;
  logic [63:0] trng_data = '0;
  logic        trng_valid = 1'b0;
  logic        busy, fault;
  logic [1:0]  fault_code;
  logic [2:0]  fifo_level;
  logic [15:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q [$];

  trng_ctrl_if #(.DW(64)) rif ();

  trng_ctrl #(
    .WARMUP_CYCLES (8),
    .DISCARD_WORDS (2),
    .REP_LIMIT     (3),
    .TIMEOUT_CYCLES(16),
    .DEPTH         (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .clear_fault(clear_fault),
    .trng_enable(trng_enable),
    .trng_data  (trng_data),
    .trng_valid (trng_valid),
    .rd         (rif),
    .busy       (busy),
    .fault      (fault),
    .fault_code (fault_code),
    .fifo_level (fifo_level),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // the handshake completes at the next posedge when both are high here
  always @(negedge clk) begin
    if (!rst && rif.rvalid && rif.rready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got 0x%0h expected no word", rif.rdata);
      end else begin
        check("pop_word", rif.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] w, input bit expect_push);
    trng_data  = w;
    trng_valid = 1'b1;
    if (expect_push) exp_q.push_back(w);
    tick();
    trng_valid = 1'b0;
  endtask

  // start, sit through 8 warm-up cycles, discard two words, land in RUN
  task automatic go_run(input logic [63:0] d0, input logic [63:0] d1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    send(d0, 0);
    send(d1, 0);
  endtask

  initial begin
    rif.rready = 1'b0;
    tick();
    tick();
    check("rst_enable", trng_enable, 0);
    check("rst_rvalid", rif.rvalid, 0);
    check("rst_rdata", rif.rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_level", fifo_level, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b0;
    tick();

    // 1: normal start
    rif.rready = 1'b1;
    start = 1'b1;
    check("en_before_start", trng_enable, 0);
    tick();
    start = 1'b0;
    check("en_after_start", trng_enable, 1);
    check("busy_warmup", busy, 1);
    send(64'h77, 0);
    send(64'h78, 0);
    repeat (6) tick();
    send(64'h1, 0);
    send(64'h2, 0);
    check("level_after_discard", fifo_level, 0);
    send(64'hA, 1);
    check("rdata_A_latency", rif.rdata, 64'hA);
    send(64'hB, 1);
    check("rdata_B_latency", rif.rdata, 64'hB);
    send(64'hC, 1);
    check("rdata_C_latency", rif.rdata, 64'hC);
    tick();
    check("s1_level", fifo_level, 0);
    check("s1_drop", drop_cnt, 0);

    // 2: repetition fault
    send(64'h5, 1);
    send(64'h5, 1);
    check("rep_no_fault_yet", fault, 0);
    send(64'h5, 0);
    check("rep_fault", fault, 1);
    check("rep_code", fault_code, 2'b01);
    check("rep_enable", trng_enable, 0);
    check("rep_level", fifo_level, 0);
    check("rep_rvalid", rif.rvalid, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fault_ignores_start", fault, 1);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    check("clr_fault", fault, 0);
    check("clr_code", fault_code, 0);
    check("clr_busy", busy, 0);

    // 3: timeout
    go_run(64'h11, 64'h12);
    repeat (15) tick();
    check("to_not_yet", fault, 0);
    tick();
    check("to_fault", fault, 1);
    check("to_code", fault_code, 2'b10);
    check("to_enable", trng_enable, 0);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;

    // 4: backpressure
    rif.rready = 1'b0;
    go_run(64'h13, 64'h14);
    for (int i = 0; i < 6; i++) send(64'h21 + 64'(i), i < 4);
    check("bp_level", fifo_level, 4);
    check("bp_drop", drop_cnt, 2);
    check("bp_rdata_head", rif.rdata, 64'h21);
    check("bp_rvalid", rif.rvalid, 1);

    // 5: push and pop together at full
    rif.rready = 1'b1;
    send(64'h27, 1);
    check("full_pp_level", fifo_level, 4);
    check("full_pp_drop", drop_cnt, 2);
    check("full_pp_rdata", rif.rdata, 64'h22);
    repeat (4) tick();
    check("drained_level", fifo_level, 0);

    // 6: stop with words buffered; word coincident with stop is dropped
    rif.rready = 1'b0;
    send(64'h31, 1);
    send(64'h32, 1);
    stop = 1'b1;
    send(64'h33, 0);
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_enable", trng_enable, 0);
    check("stop_level", fifo_level, 2);
    check("stop_rdata", rif.rdata, 64'h31);
    rif.rready = 1'b1;
    tick();
    tick();
    rif.rready = 1'b0;
    check("stop_drained", fifo_level, 0);

    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_enable", trng_enable, 0);

    // reset mid-warm-up with data buffered
    go_run(64'h41, 64'h42);
    for (int i = 0; i < 6; i++) send(64'h51 + 64'(i), 0);
    check("pre_rst_level", fifo_level, 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_drop", drop_cnt, 0);
    check("warmup_busy", busy, 1);
    tick();
    rst = 1'b1;
    tick();
    check("mrst_enable", trng_enable, 0);
    check("mrst_busy", busy, 0);
    check("mrst_level", fifo_level, 0);
    check("mrst_rvalid", rif.rvalid, 0);
    check("mrst_rdata", rif.rdata, 0);
    check("mrst_code", fault_code, 0);
    rst = 1'b0;
    tick();
    check("queue_empty", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trng_ctrl.md
Name: trng_ctrl

Overview:
Sequencing controller for the 64-bit ring-oscillator TRNG core (enable / data_out / data_valid interface). It drives the core's enable, enforces a warm-up period, discards the first post-warm-up words, and runs online health tests (repetition count, stall timeout). Words that pass are buffered in a small FIFO toward a consumer over a valid/ready handshake.

Parameters:
WARMUP_CYCLES, 1000, clk cycles after enable before any word is considered.
DISCARD_WORDS, 2, number of trng_valid words dropped after warm-up; 0 is legal.
REP_LIMIT, 3, number of identical consecutive words that triggers a fault; minimum 2.
TIMEOUT_CYCLES, 4096, maximum clk cycles between trng_valid pulses in DISCARD/RUN.
DEPTH, 4, output FIFO depth in 64-bit words; power of 2, at least 2.

Ports:
clk  in  1  system clock (50 MHz nominal)
rst  in  1  synchronous reset, active-high
start  in  1  level or pulse; starts generation when IDLE
stop  in  1  returns to IDLE and disables the core
clear_fault  in  1  leaves FAULT
trng_enable  out  1  to core enable; registered
trng_data  in  64  core data_out
trng_valid  in  1  core data_valid; 1-cycle strobe
rdata  out  64  FIFO head word
rvalid  out  1  rdata valid
rready  in  1  consumer accepts
busy  out  1  state is WARMUP, DISCARD or RUN
fault  out  1  state is FAULT
fault_code  out  2  00 none, 01 repetition, 10 timeout; held until clear_fault
fifo_level  out  clog2(DEPTH+1)  words stored
drop_cnt  out  16  words lost to a full FIFO; saturates at 0xFFFF; cleared on start

Behaviour:
- Reset values: state IDLE; trng_enable=0, rvalid=0, rdata=0, busy=0, fault=0, fault_code=00, fifo_level=0, drop_cnt=0. Internal counters, last-word register and rep_cnt are also cleared.
- Event priority, highest first: rst, fault detection, stop, start. If start and stop are both asserted in IDLE, the block stays in IDLE.
- IDLE:
  - On start, go to WARMUP.
  - trng_enable=1 from the next cycle.
  - Warm-up counter loads WARMUP_CYCLES-1; rep_cnt=0; drop_cnt=0.
- WARMUP:
  - trng_valid is ignored.
  - The counter decrements each cycle. At 0, go to DISCARD, or straight to RUN when DISCARD_WORDS=0.
  - The stall-timeout counter does not run.
- DISCARD:
  - Each trng_valid word is dropped, but it is written to the last-word register.
  - After DISCARD_WORDS words, go to RUN.
  - The timeout counter runs.
- RUN, per trng_valid word W:
  - If W equals the last word, rep_cnt increments; otherwise rep_cnt is cleared to 0.
  - When rep_cnt reaches REP_LIMIT-1 (REP_LIMIT identical words in a row), go to FAULT with code 01. W is not pushed.
  - Otherwise W is pushed to the FIFO. If the FIFO is full and there is no pop in the same cycle, W is dropped and drop_cnt increments.
  - W is always written to the last-word register.
- Timeout:
  - The counter is cleared on every trng_valid and on entry to DISCARD/RUN.
  - If it reaches TIMEOUT_CYCLES with no trng_valid, go to FAULT with code 10.
- FAULT:
  - trng_enable=0 and fault=1 from the next cycle.
  - The FIFO is flushed on entry (rvalid=0 and fifo_level=0 the next cycle), so suspect data is never released.
  - start and stop are ignored.
  - On clear_fault, go to IDLE with fault_code=00.
- stop in WARMUP, DISCARD or RUN:
  - Go to IDLE; trng_enable=0 the next cycle.
  - FIFO contents are retained and remain readable.
  - A trng_valid arriving in the same cycle as stop is dropped.
- FIFO handshake:
  - A pop happens when rvalid and rready are both high.
  - rdata and rvalid stay stable while rvalid=1 and rready=0.
  - Push into an empty FIFO: rvalid=1 and rdata=W on the next cycle (1-cycle latency).
  - Simultaneous push and pop at full: both succeed; level is unchanged; no drop.
  - Simultaneous push and pop at level 1: rdata advances to W.
  - Read and write pointers wrap modulo DEPTH.
- rst mid-operation returns every output to its reset value on the next edge, regardless of state.

Test Plan:
Parameters for all scenarios: WARMUP=8, DISCARD=2, REP_LIMIT=3, TIMEOUT=16, DEPTH=4.
1. Normal start: pulse start; feed words 0x1,0x2 (discarded), then 0xA,0xB,0xC with rready=1. Required: trng_enable rises 1 cycle after start; valid strobes during warm-up are ignored; rdata shows 0xA,0xB,0xC, each 1 cycle after its trng_valid; drop_cnt=0.
2. Repetition fault: in RUN feed 0x5,0x5,0x5. Required: first two 0x5 words pushed; third triggers fault=1, fault_code=01, trng_enable=0, fifo_level=0; clear_fault returns to IDLE with fault_code=00.
3. Timeout: in RUN hold trng_valid=0 for 16 cycles. Required: fault_code=10; trng_enable=0 the next cycle.
4. Backpressure: rready=0; push 6 distinct words. Required: fifo_level=4; drop_cnt=2; rdata holds the first word; with rready=1, the first 4 words pop in order.
5. Full with simultaneous push and pop: FIFO full, rready=1 in the same cycle as trng_valid. Required: level stays 4; drop_cnt unchanged.
6. Stop and reset: stop mid-RUN with 2 words buffered. Required: IDLE; trng_enable=0; both words still readable. start and stop together in IDLE: stays IDLE. rst during WARMUP: all outputs return to reset values.
